pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It drives the write-enable and flush controls of the IF/ID and ID/EX pipeline registers and the PC, and it arbitrates between three events: load-use hazards, taken branches resolved in EX, and jumps decoded in ID. It also sequences external interrupt entry and exit with a small state machine, and keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 32, width of each performance counter.
KERN_BIT, 31, bit of PC_plus_4_ID that marks kernel mode.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
MemRead_EX  in  1  the instruction in EX is a load.
Rt_EX  in  5  load destination register in EX.
Rs_ID  in  5  rs field of the instruction in ID.
Rt_ID  in  5  rt field of the instruction in ID.
UsesRt_ID  in  1  the instruction in ID reads rt.
BranchTaken_EX  in  1  branch in EX resolved as taken.
Jump_ID  in  1  j/jal/jr/jalr decoded in ID.
IRQ  in  1  level-sensitive external interrupt request.
PC_plus_4_ID  in  32  PC+4 of the instruction in ID; bit KERN_BIT gives the mode.
PCWrite  out  1  PC update enable.
IFIDWrite  out  1  IF/ID hold control (0 = hold).
IFFlush  out  1  clear IF/ID.
EXFlush  out  1  clear ID/EX (bubble insert).
IRQ_take  out  1  convert the instruction in ID to the exception entry (PC -> 0x80000004, $26 <- PC_plus_4_ID).
Stall_cnt  out  CNT_W  load-use stall cycles, saturating.
Flush_cnt  out  CNT_W  cycles with IFFlush or EXFlush asserted, saturating.

Behaviour:
- Reset, sampled at posedge clk with reset==0:
  - state <- RUN, irq_pend <- 0, both counters <- 0.
  - While reset==0, outputs are forced combinationally: PCWrite=0, IFIDWrite=0, IFFlush=1, EXFlush=1, IRQ_take=0.
  - A reset arriving mid-TAKE or mid-KERN aborts the sequence; nothing stays pending.
- Definitions:
  - lu = MemRead_EX & (Rt_EX!=0) & ((Rt_EX==Rs_ID) | (UsesRt_ID & Rt_EX==Rt_ID)).
  - kern = PC_plus_4_ID[KERN_BIT].
- Output priority (combinational, evaluated every cycle):
  1. BranchTaken_EX: IFFlush=1, EXFlush=1, PCWrite=1, IFIDWrite=1. Overrides lu, Jump_ID and IRQ entry.
  2. lu: PCWrite=0, IFIDWrite=0, EXFlush=1, IFFlush=0. Exactly one bubble per load-use pair; the next cycle sees lu=0 because EX now holds the bubble.
  3. Jump_ID: IFFlush=1, EXFlush=0, PCWrite=1, IFIDWrite=1.
  4. Otherwise: PCWrite=1, IFIDWrite=1, both flushes 0.
- irq_pend is set on any cycle with IRQ=1 and state==RUN. It is cleared on entry to TAKE. IRQ seen outside RUN is ignored.
- FSM (registered state; IRQ_take is a Moore output):
  - RUN: go to TAKE when irq_pend & ~kern & ~BranchTaken_EX & ~lu & ~Jump_ID. Otherwise stay in RUN.
  - TAKE, one cycle:
    - IRQ_take=1, IFFlush=1, PCWrite=1, IFIDWrite=1.
    - EXFlush follows the priority rules above, except that BranchTaken_EX here cannot occur because entry was blocked on it.
    - Always go to KERN.
  - KERN: stay while kern==1 or while the ID slot is empty (PC_plus_4_ID==0). Go to RUN on the first cycle with kern==0 and PC_plus_4_ID!=0.
  - Hazard rules apply unchanged in KERN.
- Counters:
  - Stall_cnt increments on every cycle where lu causes a stall.
  - Flush_cnt increments on every cycle with IFFlush|EXFlush, excluding reset cycles.
  - Both hold at 2^CNT_W-1; there is no wrap.
- Simultaneous events:
  - Branch plus lu: the branch wins; the load-use bubble is moot because ID is flushed.
  - lu plus Jump_ID: stall first; the jump is re-decoded on the next cycle and flushes then.
  - IRQ during a stall: stays pending until the stall clears.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams ST_RUN=2'd0, ST_TAKE=2'd1, ST_KERN=2'd2;
  - EXC_VECTOR=32'h80000004;
  - REG_XP=5'd26.
- One natural sub-module, sat_counter (parameter W; inputs clk, reset, inc; output cnt), instantiated twice.
- The hazard-detect and priority logic stays in the top module.

Test Plan:
- Load-use: lw with Rt_EX=5, Rs_ID=5, MemRead_EX=1 for 1 cycle -> PCWrite=0, IFIDWrite=0, EXFlush=1 for exactly 1 cycle; Stall_cnt=1.
- Load to $0: Rt_EX=0, Rs_ID=0, MemRead_EX=1 -> no stall; PCWrite=1, Stall_cnt=0.
- Branch plus lu in the same cycle: BranchTaken_EX=1 with lu true -> IFFlush=1, EXFlush=1, PCWrite=1; Stall_cnt unchanged; Flush_cnt+1.
- IRQ in user mode: IRQ pulse of 1 cycle with kern=0 -> TAKE next cycle with IRQ_take=1 for 1 cycle; state KERN; return to RUN when PC_plus_4_ID=0x00400010.
- IRQ deferred: IRQ pulse during an lu stall, then while BranchTaken_EX=1 -> IRQ_take asserted only on the first clean cycle afterwards. An IRQ held while in KERN does not cause re-entry.
- Reset mid-TAKE: reset=0 for 1 cycle -> state RUN, irq_pend=0, counters 0; IFFlush=1, EXFlush=1, PCWrite=0 during the reset cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline control slice: FSM states and exception constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TAKE = 2'd1,
        ST_KERN = 2'd2
    } state_t;

    localparam logic [31:0] EXC_VECTOR = 32'h80000004;
    localparam logic [4:0]  REG_XP     = 5'd26;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, branch and jump
// arbitration plus interrupt entry/exit sequencing and performance counters.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int KERN_BIT = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rt_EX,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             BranchTaken_EX,
    input  logic             Jump_ID,
    input  logic             IRQ,
    input  logic [31:0]      PC_plus_4_ID,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFFlush,
    output logic             EXFlush,
    output logic             IRQ_take,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Flush_cnt
);

    state_t state, state_nxt;
    logic   irq_pend;
    logic   lu, kern, id_empty, go_take, stall;

    assign lu = MemRead_EX && (Rt_EX != 5'd0) &&
                ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));
    assign kern     = PC_plus_4_ID[KERN_BIT];
    assign id_empty = (PC_plus_4_ID == 32'd0);
    assign go_take  = (state == ST_RUN) && irq_pend && !kern &&
                      !BranchTaken_EX && !lu && !Jump_ID;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:  if (go_take) state_nxt = ST_TAKE;
            ST_TAKE: state_nxt = ST_KERN;
            ST_KERN: if (!kern && !id_empty) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_RUN;
            irq_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go_take)
                irq_pend <= 1'b0;
            else if (IRQ && (state == ST_RUN))
                irq_pend <= 1'b1;
        end
    end

    // TAKE keeps the front end moving so the exception entry itself proceeds;
    // only the ID/EX bubble still follows the hazard priority.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFFlush   = 1'b0;
        EXFlush   = 1'b0;
        IRQ_take  = 1'b0;
        stall     = 1'b0;
        if (!reset) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFFlush   = 1'b1;
            EXFlush   = 1'b1;
        end else if (state == ST_TAKE) begin
            IRQ_take = 1'b1;
            IFFlush  = 1'b1;
            EXFlush  = BranchTaken_EX || lu;
        end else if (BranchTaken_EX) begin
            IFFlush = 1'b1;
            EXFlush = 1'b1;
        end else if (lu) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            EXFlush   = 1'b1;
            stall     = 1'b1;
        end else if (Jump_ID) begin
            IFFlush = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .cnt   (Stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (reset && (IFFlush || EXFlush)),
        .cnt   (Flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead_EX = 1'b0, UsesRt_ID = 1'b0, BranchTaken_EX = 1'b0;
    logic        Jump_ID = 1'b0, IRQ = 1'b0;
    logic [4:0]  Rt_EX = '0, Rs_ID = '0, Rt_ID = '0;
    logic [31:0] PC_plus_4_ID = '0;
    logic        PCWrite, IFIDWrite, IFFlush, EXFlush, IRQ_take;
    logic [31:0] Stall_cnt, Flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32), .KERN_BIT(31)) dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead_EX     (MemRead_EX),
        .Rt_EX          (Rt_EX),
        .Rs_ID          (Rs_ID),
        .Rt_ID          (Rt_ID),
        .UsesRt_ID      (UsesRt_ID),
        .BranchTaken_EX (BranchTaken_EX),
        .Jump_ID        (Jump_ID),
        .IRQ            (IRQ),
        .PC_plus_4_ID   (PC_plus_4_ID),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .IFFlush        (IFFlush),
        .EXFlush        (EXFlush),
        .IRQ_take       (IRQ_take),
        .Stall_cnt      (Stall_cnt),
        .Flush_cnt      (Flush_cnt)
    );

    // control bits {PCWrite, IFIDWrite, IFFlush, EXFlush, IRQ_take}
    localparam logic [4:0] C_NORM  = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_BR    = 5'b11110;
    localparam logic [4:0] C_JMP   = 5'b11100;
    localparam logic [4:0] C_RST   = 5'b00110;
    localparam logic [4:0] C_TAKE  = 5'b11101;
    localparam logic [4:0] C_TKLU  = 5'b11111;
    localparam logic [31:0] PC_U   = 32'h00400010;
    localparam logic [31:0] PC_K   = 32'h80000100;

    typedef struct {
        string      nm;
        logic [4:0] ctl;
        int         s;
        int         f;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // rs/rt encode {MemRead, Rt_EX, Rs_ID, Rt_ID, UsesRt} compactly via args
    task automatic step(input string nm, input logic rst, input logic mr,
                        input logic [4:0] rte, input logic [4:0] rsi,
                        input logic [4:0] rti, input logic ur, input logic br,
                        input logic jp, input logic irq, input logic [31:0] pc,
                        input logic [4:0] ctl, input int s, input int f);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; MemRead_EX = mr; Rt_EX = rte; Rs_ID = rsi; Rt_ID = rti;
        UsesRt_ID = ur; BranchTaken_EX = br; Jump_ID = jp; IRQ = irq;
        PC_plus_4_ID = pc;
        e.nm = nm; e.ctl = ctl; e.s = s; e.f = f;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {PCWrite, IFIDWrite, IFFlush, EXFlush, IRQ_take};
                total++;
                if (act !== e.ctl) begin
                    bad++;
                    $display("FAIL %s ctl: got %b want %b", e.nm, act, e.ctl);
                end
                total++;
                if (Stall_cnt !== 32'(e.s)) begin
                    bad++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, Stall_cnt, e.s);
                end
                total++;
                if (Flush_cnt !== 32'(e.f)) begin
                    bad++;
                    $display("FAIL %s flush_cnt: got %0d want %0d", e.nm, Flush_cnt, e.f);
                end
            end
        end
    end

    initial begin : stim
        //        name        rst mr rte rsi rti ur br jp irq pc    ctl      S  F
        step("rst0",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0,    C_RST,   0, 0);
        step("idle",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    C_NORM,  0, 0);
        step("lu_rs",       1, 1, 5, 5, 0, 0, 0, 0, 0, 0,    C_STALL, 0, 0);
        step("bubble",      1, 0, 0, 5, 0, 0, 0, 0, 0, 0,    C_NORM,  1, 1);
        step("ld_r0",       1, 1, 0, 0, 0, 0, 0, 0, 0, 0,    C_NORM,  1, 1);
        step("lu_rt",       1, 1, 7, 3, 7, 1, 0, 0, 0, 0,    C_STALL, 1, 1);
        step("rt_unused",   1, 1, 7, 3, 7, 0, 0, 0, 0, 0,    C_NORM,  2, 2);
        step("br_lu",       1, 1, 5, 5, 0, 0, 1, 0, 0, 0,    C_BR,    2, 2);
        step("jump",        1, 0, 0, 0, 0, 0, 0, 1, 0, 0,    C_JMP,   2, 3);
        step("lu_jump",     1, 1, 5, 5, 0, 0, 0, 1, 0, 0,    C_STALL, 2, 4);
        step("jump_redec",  1, 0, 0, 5, 0, 0, 0, 1, 0, 0,    C_JMP,   3, 5);
        step("idle2",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    C_NORM,  3, 6);
        // user-mode interrupt
        step("irq_user",    1, 0, 0, 0, 0, 0, 0, 0, 1, PC_U, C_NORM,  3, 6);
        step("irq_pend",    1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  3, 6);
        step("take",        1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_TAKE,  3, 6);
        step("kern_empty",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0,    C_NORM,  3, 7);
        step("kern_irq",    1, 0, 0, 0, 0, 0, 0, 0, 1, PC_K, C_NORM,  3, 7);
        step("kern_exit",   1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  3, 7);
        step("no_reentry1", 1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  3, 7);
        step("no_reentry2", 1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  3, 7);
        // interrupt deferred behind stall, branch and jump
        step("irq_in_lu",   1, 1, 5, 5, 0, 0, 0, 0, 1, PC_U, C_STALL, 3, 7);
        step("def_br",      1, 0, 0, 0, 0, 0, 1, 0, 0, PC_U, C_BR,    4, 8);
        step("def_lu",      1, 1, 5, 5, 0, 0, 0, 0, 0, PC_U, C_STALL, 4, 9);
        step("def_jump",    1, 0, 0, 0, 0, 0, 0, 1, 0, PC_U, C_JMP,   5, 10);
        step("def_clean",   1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  5, 11);
        step("take_lu",     1, 1, 5, 5, 0, 0, 0, 0, 0, PC_U, C_TKLU,  5, 11);
        step("kern_out",    1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  5, 12);
        // reset during TAKE
        step("irq3",        1, 0, 0, 0, 0, 0, 0, 0, 1, PC_U, C_NORM,  5, 12);
        step("to_take",     1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  5, 12);
        step("rst_in_take", 0, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_RST,   5, 12);
        step("post_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  0, 0);
        // reset with an interrupt pending
        step("irq4",        1, 0, 0, 0, 0, 0, 0, 0, 1, PC_U, C_NORM,  0, 0);
        step("rst_pend",    0, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_RST,   0, 0);
        step("pend_gone1",  1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  0, 0);
        step("pend_gone2",  1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  0, 0);
        step("pend_gone3",  1, 0, 0, 0, 0, 0, 0, 0, 0, PC_U, C_NORM,  0, 0);
        repeat (4) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
